// File: rtl/regfile_sb_if.sv
// Writeback, decode-read, issue and ECALL-export signals of the integer register file.
// The master side is the pipeline and the slave side is regfile_sb.
interface regfile_sb_if #(
  parameter int REGBITS = 5,
  parameter int LOGSIZE = 64
);
  logic [REGBITS-1:0]        wr_rd;
  logic [LOGSIZE-1:0]        wr_data;
  logic [REGBITS-1:0]        rs1_addr;
  logic [REGBITS-1:0]        rs2_addr;
  logic [LOGSIZE-1:0]        rs1_data;
  logic [LOGSIZE-1:0]        rs2_data;
  logic                      iss_valid;
  logic [REGBITS-1:0]        iss_rd;
  logic                      stall;
  logic                      flush;
  logic [7:0][LOGSIZE-1:0]   ecall_reg_val;
  logic [REGBITS:0]          busy_cnt;

  modport master (
    output wr_rd, wr_data, rs1_addr, rs2_addr, iss_valid, iss_rd, flush,
    input  rs1_data, rs2_data, stall, ecall_reg_val, busy_cnt
  );

  modport slave (
    input  wr_rd, wr_data, rs1_addr, rs2_addr, iss_valid, iss_rd, flush,
    output rs1_data, rs2_data, stall, ecall_reg_val, busy_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with a busy-bit scoreboard for the in-order pipeline.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to reads and to the hazard check.
module regfile_sb #(
  parameter int                 REGBITS = 5,
  parameter int                 LOGSIZE = 64,
  parameter logic [LOGSIZE-1:0] SP_INIT = 64'h0
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);
  localparam int NREGS = 1 << REGBITS;

  logic [LOGSIZE-1:0] regs [NREGS-1:1];
  logic [NREGS-1:1]   busy;
  logic [NREGS-1:1]   busy_nxt;
  logic [NREGS-1:0]   busy_eff;
  logic [REGBITS:0]   busy_cnt_q;
  logic [REGBITS:0]   cnt_nxt;
  logic               wr_en;
  logic               issue_ok;

  assign wr_en = (bus.wr_rd != '0);

  // Bit 0 of busy_eff stands in for x0, which is never busy.
  always_comb begin
    busy_eff = {busy, 1'b0};
`ifdef REGFILE_BYPASS_EN
    if (wr_en) busy_eff[bus.wr_rd] = 1'b0;
`endif
  end

  assign bus.stall = bus.iss_valid &
                     (busy_eff[bus.rs1_addr] | busy_eff[bus.rs2_addr] | busy_eff[bus.iss_rd]);

  assign issue_ok = bus.iss_valid & ~bus.stall & (bus.iss_rd != '0);

  // Writeback clears first so an issue to the same register wins; flush overrides both.
  always_comb begin
    busy_nxt = busy;
    if (wr_en) busy_nxt[bus.wr_rd] = 1'b0;
    if (bus.flush) busy_nxt = '0;
    else if (issue_ok) busy_nxt[bus.iss_rd] = 1'b1;
    cnt_nxt = '0;
    for (int i = 1; i < NREGS; i++) begin
      cnt_nxt = cnt_nxt + {{REGBITS{1'b0}}, busy_nxt[i]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy       <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy       <= busy_nxt;
      busy_cnt_q <= cnt_nxt;
    end
  end

  assign bus.busy_cnt = busy_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NREGS; i++) begin
        regs[i] <= (i == 2) ? SP_INIT : '0;
      end
    end else if (wr_en) begin
      regs[bus.wr_rd] <= bus.wr_data;
    end
  end

  always_comb begin
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    if (bus.rs1_addr != '0) bus.rs1_data = regs[bus.rs1_addr];
    if (bus.rs2_addr != '0) bus.rs2_data = regs[bus.rs2_addr];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (bus.rs1_addr == bus.wr_rd)) bus.rs1_data = bus.wr_data;
    if (wr_en && (bus.rs2_addr == bus.wr_rd)) bus.rs2_data = bus.wr_data;
`endif
  end

  // a0..a7 come straight from storage so ECALL sees only committed values.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      bus.ecall_reg_val[i] = regs[10+i];
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed-vector bench for regfile_sb; expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_regfile_sb;
  localparam logic [63:0] SP = 64'h8000;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_vec  = 0;
  int   n_miss = 0;

  regfile_sb_if #(.REGBITS(5), .LOGSIZE(64)) bus ();

  regfile_sb #(.REGBITS(5), .LOGSIZE(64), .SP_INIT(SP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_rd     = '0;
    bus.wr_data   = '0;
    bus.rs1_addr  = '0;
    bus.rs2_addr  = '0;
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
    bus.flush     = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // warm-up: put state in place so reset has something to clear
    bus.wr_rd = 5; bus.wr_data = 64'h77; bus.iss_valid = 1'b1; bus.iss_rd = 6; #1;
    chk("issue_free_stall", bus.stall, 0);
    step(); idle();
    bus.wr_rd = 10; bus.wr_data = 64'h99;
    step(); idle();
    bus.rs1_addr = 5; bus.rs2_addr = 2; #1;
    chk("wr_x5", bus.rs1_data, 64'h77);
    chk("sp_read", bus.rs2_data, SP);
    chk("cnt_one", bus.busy_cnt, 1);
    chk("ecall0_pre_rst", bus.ecall_reg_val[0], 64'h99);
    bus.iss_valid = 1'b1; bus.iss_rd = 6; #1;
    chk("waw_stall", bus.stall, 1);

    // asynchronous reset mid-cycle
    bus.rs1_addr = 2; bus.rs2_addr = 5;
    rst = 1'b0; #1;
    chk("rst_rs1_sp", bus.rs1_data, SP);
    chk("rst_rs2_x5", bus.rs2_data, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_cnt", bus.busy_cnt, 0);
    chk("rst_ecall0", bus.ecall_reg_val[0], 0);
    @(posedge clk);
    #1 rst = 1'b1;
    idle();

    // x0 ignores writes and issues
    bus.wr_rd = 0; bus.wr_data = 64'hDEAD; bus.iss_valid = 1'b1; bus.iss_rd = 0; #1;
    chk("x0_stall", bus.stall, 0);
    step(); idle();
    bus.iss_valid = 1'b1; #1;
    chk("x0_cnt", bus.busy_cnt, 0);
    chk("x0_read", bus.rs1_data, 0);
    chk("x0_rs1_stall", bus.stall, 0);
    idle();

    // RAW on x5
    bus.iss_valid = 1'b1; bus.iss_rd = 5; #1;
    chk("raw_issue_stall", bus.stall, 0);
    step(); idle();
    bus.iss_valid = 1'b1; bus.rs1_addr = 5; #1;
    chk("raw_stall", bus.stall, 1);
    step();
    chk("raw_held_cnt", bus.busy_cnt, 1);
    bus.wr_rd = 5; bus.wr_data = 64'h1234; #1;
    chk("raw_wr_cycle_stall", bus.stall, BYP ? 64'd0 : 64'd1);
    chk("raw_wr_cycle_data", bus.rs1_data, BYP ? 64'h1234 : 64'h0);
    step();
    bus.wr_rd = 0; bus.wr_data = '0; #1;
    chk("raw_after_stall", bus.stall, 0);
    chk("raw_after_data", bus.rs1_data, 64'h1234);
    chk("raw_after_cnt", bus.busy_cnt, 0);
    idle();

    // write and issue to the same register in one cycle
    bus.iss_valid = 1'b1; bus.iss_rd = 7;
    step(); idle();
    chk("col_busy7_cnt", bus.busy_cnt, 1);
    bus.wr_rd = 7; bus.wr_data = 64'hABCD; bus.iss_valid = 1'b1; bus.iss_rd = 7; #1;
    chk("col_busy7_stall", bus.stall, BYP ? 64'd0 : 64'd1);
    step(); idle();
    bus.rs1_addr = 7; #1;
    chk("col_x7_data", bus.rs1_data, 64'hABCD);
    chk("col_x7_cnt", bus.busy_cnt, BYP ? 64'd1 : 64'd0);
    idle();
    bus.wr_rd = 8; bus.wr_data = 64'h5555; bus.iss_valid = 1'b1; bus.iss_rd = 8; #1;
    chk("col_x8_stall", bus.stall, 0);
    step(); idle();
    bus.rs2_addr = 8; #1;
    chk("col_x8_data", bus.rs2_data, 64'h5555);
    chk("col_x8_cnt", bus.busy_cnt, BYP ? 64'd2 : 64'd1);
    bus.iss_valid = 1'b1; bus.rs2_addr = 0; bus.rs1_addr = 8; #1;
    chk("col_x8_busy", bus.stall, 1);
    idle();

    // flush
    bus.flush = 1'b1;
    step(); idle();
    chk("flush_clear_cnt", bus.busy_cnt, 0);
    bus.iss_valid = 1'b1; bus.iss_rd = 1;  step();
    bus.iss_rd = 3;  step();
    bus.iss_rd = 20; step();
    idle(); #1;
    chk("flush_pre_cnt", bus.busy_cnt, 3);
    bus.flush = 1'b1; bus.iss_valid = 1'b1; bus.iss_rd = 9;
    bus.wr_rd = 4; bus.wr_data = 64'h4444;
    step(); idle();
    bus.iss_valid = 1'b1; bus.iss_rd = 9; bus.rs1_addr = 4; #1;
    chk("flush_cnt", bus.busy_cnt, 0);
    chk("flush_x9_free", bus.stall, 0);
    chk("flush_x4_data", bus.rs1_data, 64'h4444);
    idle();

    // ECALL argument export
    bus.wr_rd = 17; bus.wr_data = 64'd93;  step();
    bus.wr_rd = 10; bus.wr_data = 64'd1;   step();
    bus.wr_rd = 11; bus.wr_data = 64'h100; #1;
    chk("ecall1_not_bypassed", bus.ecall_reg_val[1], 0);
    step(); idle();
    bus.rs2_addr = 17; #1;
    chk("ecall7", bus.ecall_reg_val[7], 64'd93);
    chk("ecall0", bus.ecall_reg_val[0], 64'd1);
    chk("ecall1", bus.ecall_reg_val[1], 64'h100);
    chk("x17_read", bus.rs2_data, 64'd93);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
